cell_osc_counter: RTL and testbench

- Measures a standard-cell ring oscillator (or a delay chain built from library cells) by counting rising edges of its output over a programmable window of CLK cycles.
- It is the read-out end of the library's characterization and sensor loop: the cell ring produces the oscillation, and this block digitizes it.
- It sits beside the generated ring in sensor and characterization macros, and its result is read by a host or scan logic.

---
 rtl/cell_osc_counter.sv | 98 +++++++++
 tb/tb_cell_osc_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cell_osc_counter.sv
// cell_osc_counter
//   Digitizes a standard-cell ring oscillator by counting its rising edges
//   over a programmable window of CLK cycles.
//
//   Ports
//     CLK      system clock, all state on rising edge
//     RST      asynchronous active-high reset
//     start    measurement request, honoured only in IDLE
//     win_len  window length in CLK cycles, captured when start is accepted
//     osc_in   oscillator output (asynchronous to CLK, below CLK/2)
//     busy     high from ARM through the last MEAS cycle
//     done     one-cycle pulse when count/ovf are valid
//     count    rising edges seen in the window (saturating)
//     ovf      sticky saturation flag for the last window
module cell_osc_counter #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             osc_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  state_t           state;
  logic [WIN_W-1:0] timer;
  logic             s1, s2, s3;
  logic             rise;

  // s1/s2 resynchronize the ring output; s3 is history for edge detect.
  assign rise = s2 & ~s3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      s1   <= osc_in;
      s2   <= s1;
      s3   <= s2;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // win_len is captured in the accepting cycle so later changes
            // to the input cannot disturb the running window.
            state <= ARM;
            busy  <= 1'b1;
            timer <= win_len;
          end
        end
        ARM: begin
          count <= '0;
          ovf   <= 1'b0;
          if (timer == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            if (count == {CNT_W{1'b1}}) ovf <= 1'b1;
            else                        count <= count + 1'b1;
          end
          timer <= timer - 1'b1;
          // timer==1 marks the final window cycle.
          if (timer == {{(WIN_W-1){1'b0}}, 1'b1}) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_osc_counter.sv
// Testbench for cell_osc_counter: two instances (CNT_W=16 and CNT_W=4) share
// all inputs. A reference model counts rising edges of the recorded osc_in
// history seen through the two-cycle synchronizer over the window cycles.
module tb_cell_osc_counter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic        osc_in = 1'b0;
  logic        busy, done, ovf;
  logic [15:0] count;
  logic        busy4, done4, ovf4;
  logic [3:0]  count4;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mode = 0;
  bit o [0:16383];

  cell_osc_counter #(.CNT_W(16), .WIN_W(16)) dut (
    .CLK(CLK), .RST(RST), .start(start), .win_len(win_len), .osc_in(osc_in),
    .busy(busy), .done(done), .count(count), .ovf(ovf));

  cell_osc_counter #(.CNT_W(4), .WIN_W(16)) dut4 (
    .CLK(CLK), .RST(RST), .start(start), .win_len(win_len), .osc_in(osc_in),
    .busy(busy4), .done(done4), .count(count4), .ovf(ovf4));

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Oscillator source: value for cycle cyc, recorded for the model.
  always @(negedge CLK) begin
    bit v;
    case (mode)
      0: v = 1'b0;
      1: v = 1'b1;
      2: v = ((cyc % 4) < 2);
      3: v = cyc[0];
      default: v = 1'($urandom_range(0, 1));
    endcase
    osc_in = v;
    if (cyc < 16384) o[cyc] = v;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  // Edges the window sees: cycle c counts if osc was high two cycles
  // earlier and low three cycles earlier (synchronizer delay).
  function automatic int model_raw(input int t, input int w);
    int n = 0;
    for (int c = t + 2; c <= t + 1 + w; c++)
      if (o[c-2] && !o[c-3]) n++;
    return n;
  endfunction

  // One measurement; exp_* < 0 means use the model only.
  task automatic run(input int w, input int exp_cnt, input int exp4, input int exp_ovf4,
                     input int extra_at, input int rst_at);
    int t, raw;
    @(negedge CLK);
    start = 1'b1; win_len = 16'(w); t = cyc;
    @(negedge CLK);
    start = 1'b0;
    for (int k = 1; k <= w + 8; k++) begin
      chk("busy", busy, (k >= 1 && k <= w + 1));
      chk("done", done, (k == w + 2));
      chk("busy4", busy4, (k >= 1 && k <= w + 1));
      if (k == w + 2) begin
        raw = model_raw(t, w);
        chk("count", count, raw);
        chk("ovf", ovf, 0);
        chk("count4", count4, (raw > 15) ? 15 : raw);
        chk("ovf4", ovf4, (raw > 15));
        if (exp_cnt >= 0) chk("count_spec", count, exp_cnt);
        if (exp4 >= 0) chk("count4_spec", count4, exp4);
        if (exp_ovf4 >= 0) chk("ovf4_spec", ovf4, exp_ovf4);
      end
      if (k == rst_at) begin
        RST = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        break;
      end
      start = (k == extra_at);
      if (k == extra_at) win_len = 16'd100;
      @(negedge CLK);
    end
    start = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    // Reset asserted from time zero: outputs cleared without any clock.
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_count", count, 0);
    chk("init_ovf", ovf, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_count", count, 0);
    end

    mode = 2; repeat (4) @(negedge CLK);
    run(100, 25, 15, 1, -1, -1);
    mode = 1; repeat (4) @(negedge CLK);
    run(50, 0, 0, 0, -1, -1);
    mode = 0; repeat (4) @(negedge CLK);
    run(50, 0, 0, 0, -1, -1);
    mode = 2; repeat (4) @(negedge CLK);
    run(0, 0, 0, 0, -1, -1);
    mode = 3; repeat (4) @(negedge CLK);
    run(40, 20, 15, 1, -1, -1);
    run(8, 4, 4, 0, -1, -1);
    run(40, 20, 15, 1, -1, -1);

    // Asynchronous reset mid-cycle in IDLE clears held results at once.
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    chk("arst_count4", count4, 0);
    chk("arst_ovf4", ovf4, 0);
    chk("arst_count", count, 0);
    @(negedge CLK); RST = 1'b0;
    repeat (5) @(negedge CLK);

    // start while busy, start in the done cycle, reset mid-run, fresh run.
    mode = 2; repeat (4) @(negedge CLK);
    run(100, 25, -1, -1, 20, -1);
    run(30, -1, -1, -1, 32, -1);
    run(100, -1, -1, -1, -1, 30);
    repeat (4) @(negedge CLK);
    run(100, 25, 15, 1, -1, -1);

    // start held high: runs back to back with one IDLE cycle between.
    begin
      @(negedge CLK);
      start = 1'b1; win_len = 16'd5;
      for (int k = 1; k <= 19; k++) begin
        @(negedge CLK);
        chk("hold_busy", busy, ((k >= 1 && k <= 6) || (k >= 9 && k <= 14) || k >= 17));
        chk("hold_done", done, (k == 7 || k == 15));
      end
      start = 1'b0;
      repeat (20) @(negedge CLK);
    end

    // Randomized oscillator activity and window lengths.
    mode = 4;
    for (int r = 0; r < 20; r++) begin
      repeat (4) @(negedge CLK);
      run(int'($urandom_range(0, 60)), -1, -1, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
